// File: rtl/wb_queue.sv
// wb_queue: register-file write-back queue.
//   Buffers register write-back requests in a circular FIFO and drains them
//   into the register-file write port one per cycle, in acceptance order.
//   Pending entries can be looked up by operand address so that readers can
//   detect a pending write and take its data as a bypass.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset, discards all entries
//   wr_valid_i       write-back request valid
//   wr_ready_o       queue can accept a request this cycle
//   wr_addr_i        destination register (0 = no write, handshake only)
//   wr_data_i        destination register data
//   stall_i          register-file write port unavailable this cycle
//   RegWrite_o       register-file write strobe
//   RDaddr_o         register-file write address (head entry, 0 when empty)
//   RDdata_o         register-file write data (head entry, 0 when empty)
//   RSaddr_i/RTaddr_i  operand addresses for pending-write lookup
//   RS_hit_o/RT_hit_o  operand has a pending write
//   RS_fwd_o/RT_fwd_o  data of the youngest pending write to the operand
//   count_o          number of valid entries
module wb_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [4:0]                 wr_addr_i,
    input  logic [31:0]                wr_data_i,
    input  logic                       stall_i,
    output logic                       RegWrite_o,
    output logic [4:0]                 RDaddr_o,
    output logic [31:0]                RDdata_o,
    input  logic [4:0]                 RSaddr_i,
    input  logic [4:0]                 RTaddr_i,
    output logic                       RS_hit_o,
    output logic                       RT_hit_o,
    output logic [31:0]                RS_fwd_o,
    output logic [31:0]                RT_fwd_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          not_empty;
    logic          push;
    logic          pop;
    logic [32:0]   rs_res;
    logic [32:0]   rt_res;

    assign not_empty  = (count != '0);
    // Ready depends only on the registered count, never on a same-cycle pop.
    assign wr_ready_o = (count < CW'(DEPTH));
    // Requests to register 0 complete the handshake but are dropped.
    assign push       = wr_valid_i && wr_ready_o && (wr_addr_i != '0);
    assign RegWrite_o = not_empty && !stall_i;
    assign pop        = RegWrite_o;

    // Outputs come only from stored entries; no fall-through from wr_data_i.
    assign RDaddr_o   = not_empty ? addr_q[head] : '0;
    assign RDdata_o   = not_empty ? data_q[head] : '0;
    assign count_o    = count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail] <= wr_addr_i;
            data_q[tail] <= wr_data_i;
        end
    end

    // Walk entries oldest to youngest so the last match (youngest) wins.
    // The head entry is included even when it is being popped this cycle.
    function automatic logic [32:0] lookup(input logic [4:0] a);
        logic [32:0]   r;
        logic [PW-1:0] idx;
        r = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((a != '0) && (CW'(i) < count) && (addr_q[idx] == a)) begin
                r = {1'b1, data_q[idx]};
            end
        end
        return r;
    endfunction

    always_comb begin
        rs_res = lookup(RSaddr_i);
        rt_res = lookup(RTaddr_i);
    end

    assign RS_hit_o = rs_res[32];
    assign RS_fwd_o = rs_res[31:0];
    assign RT_hit_o = rt_res[32];
    assign RT_fwd_o = rt_res[31:0];

endmodule
